// File: rtl/vic_cpu_if_if.sv
// ============================================================================
// Module   : vic_cpu_if_if
// Brief    : Bus bundle between the interrupt controller / CPU core and the
//            vector interrupt CPU interface block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vic_cpu_if_if;
    logic        i_irq;
    logic [4:0]  i_irq_addr;
    logic        o_irq_ack;
    logic        i_cpu_int_en;
    logic        i_vt_we;
    logic [4:0]  i_vt_addr;
    logic [31:0] i_vt_data;
    logic        o_jump_req;
    logic [31:0] o_jump_addr;
    logic        i_jump_ack;
    logic        i_reti;
    logic        o_in_isr;
    logic [4:0]  o_cur_irq;

    modport slave (
        input  i_irq, i_irq_addr, i_cpu_int_en, i_vt_we, i_vt_addr, i_vt_data,
               i_jump_ack, i_reti,
        output o_irq_ack, o_jump_req, o_jump_addr, o_in_isr, o_cur_irq
    );

    modport master (
        output i_irq, i_irq_addr, i_cpu_int_en, i_vt_we, i_vt_addr, i_vt_data,
               i_jump_ack, i_reti,
        input  o_irq_ack, o_jump_req, o_jump_addr, o_in_isr, o_cur_irq
    );
endinterface

`default_nettype wire

// File: rtl/vic_cpu_if.sv
// ============================================================================
// Module   : vic_cpu_if
// Brief    : Vectored interrupt entry/return sequencer with a 31-entry vector
//            table. Define VIC_CPU_IF_NEST_EN to compile in preemption.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vic_cpu_if #(
    parameter logic [31:0] VT_RESET_BASE = 32'h0000_0100,
    parameter int          NEST_DEPTH    = 4
) (
    input  wire logic     i_clk,
    input  wire logic     i_rst,
    vic_cpu_if_if.slave   bus
);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_latch   = 3'd1;
    localparam logic [2:0] c_jump    = 3'd2;
    localparam logic [2:0] c_ack     = 3'd3;
    localparam logic [2:0] c_service = 3'd4;

    localparam int         c_entries = 31;
    localparam logic [4:0] c_no_irq  = 5'd31;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_table [0:c_entries-1];
    logic [4:0]  r_latched;
    logic [31:0] r_jump_addr;
    logic        r_in_isr;
    logic [4:0]  r_cur_irq;
    logic        w_take;
    logic        w_return_idle;
    logic        w_preempt;

    // Number 31 is reserved as "nothing pending".
    assign w_take = bus.i_irq && bus.i_cpu_int_en && (bus.i_irq_addr != c_no_irq);

`ifdef VIC_CPU_IF_NEST_EN
    localparam int SP_W  = $clog2(NEST_DEPTH + 1);
    localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    logic [4:0]      r_stack [0:NEST_DEPTH-1];
    logic [SP_W-1:0] r_sp;
    logic [SP_W-1:0] w_top;
    logic            w_full;
    logic            w_empty;

    assign w_top         = r_sp - 1'b1;
    assign w_full        = (r_sp == SP_W'(NEST_DEPTH));
    assign w_empty       = (r_sp == '0);
    assign w_return_idle = w_empty;
    assign w_preempt     = w_take && (bus.i_irq_addr < r_cur_irq) && !w_full;
`else
    logic w_unused_depth;

    assign w_unused_depth = (NEST_DEPTH != 0);
    assign w_return_idle  = 1'b1;
    assign w_preempt      = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // A return always wins over a simultaneous request; the request is
    // sampled again from IDLE on the following cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:    if (w_take) w_next = c_latch;
            c_latch:   w_next = c_jump;
            c_jump:    if (bus.i_jump_ack) w_next = c_ack;
            c_ack:     w_next = c_service;
            c_service: begin
                if (bus.i_reti) begin
                    if (w_return_idle) w_next = c_idle;
                end else if (w_preempt) begin
                    w_next = c_latch;
                end
            end
            default:   w_next = c_idle;
        endcase
    end

    always_comb begin
        bus.o_jump_req = (r_state == c_jump);
        bus.o_irq_ack  = (r_state == c_ack);
    end

    assign bus.o_jump_addr = r_jump_addr;
    assign bus.o_in_isr    = r_in_isr;
    assign bus.o_cur_irq   = r_cur_irq;

    // The LATCH read uses the pre-edge table contents, so a write to the same
    // entry in that cycle only affects later entries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < c_entries; i++) begin
                r_table[i] <= VT_RESET_BASE + 32'(4 * i);
            end
            r_latched   <= '0;
            r_jump_addr <= '0;
            r_in_isr    <= 1'b0;
            r_cur_irq   <= '0;
        end else begin
            if (bus.i_vt_we && (bus.i_vt_addr != c_no_irq)) begin
                r_table[bus.i_vt_addr] <= bus.i_vt_data;
            end
            case (r_state)
                c_idle: begin
                    if (w_take) r_latched <= bus.i_irq_addr;
                end
                c_latch: begin
                    r_jump_addr <= r_table[r_latched];
                end
                c_jump: begin
                    if (bus.i_jump_ack) begin
                        r_in_isr  <= 1'b1;
                        r_cur_irq <= r_latched;
                    end
                end
                c_service: begin
                    if (bus.i_reti) begin
`ifdef VIC_CPU_IF_NEST_EN
                        if (w_empty) begin
                            r_in_isr <= 1'b0;
                        end else begin
                            r_cur_irq <= r_stack[w_top[IDX_W-1:0]];
                        end
`else
                        r_in_isr <= 1'b0;
`endif
                    end else if (w_preempt) begin
                        r_latched <= bus.i_irq_addr;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VIC_CPU_IF_NEST_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (r_state == c_service) begin
            if (bus.i_reti) begin
                if (!w_empty) r_sp <= w_top;
            end else if (w_preempt) begin
                r_stack[r_sp[IDX_W-1:0]] <= r_cur_irq;
                r_sp                     <= r_sp + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vic_cpu_if.sv
// ============================================================================
// Module   : tb_vic_cpu_if
// Brief    : Randomised scoreboard bench for vic_cpu_if against a table model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vic_cpu_if;

    localparam logic [31:0] BASE = 32'h0000_0100;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  num;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];
    logic [31:0] model_table [0:30];

    vic_cpu_if_if bus ();

    vic_cpu_if #(.VT_RESET_BASE(BASE), .NEST_DEPTH(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 31; i++) model_table[i] = BASE + 32'(4 * i);
    endtask

    task automatic push_exp(input int n);
        exp_t e;
        e.addr = model_table[n];
        e.num  = 5'(n);
        exp_q.push_back(e);
    endtask

    task automatic table_write(input int a, input logic [31:0] d);
        bus.i_vt_we   = 1'b1;
        bus.i_vt_addr = 5'(a);
        bus.i_vt_data = d;
        if (a < 31) model_table[a] = d;
    endtask

    // Monitor: any redirect or acknowledge must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_jump_req) begin
                if (exp_q.size() == 0) chk("unexpected_jump_req", 1, 0);
                else chk("jump_addr", bus.o_jump_addr, exp_q[0].addr);
            end
            if (bus.o_irq_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_irq_ack", 1, 0);
                end else begin
                    chk("ack_cur_irq", 32'(bus.o_cur_irq), 32'(exp_q[0].num));
                    chk("ack_in_isr", 32'(bus.o_in_isr), 1);
                    chk("ack_jump_addr", bus.o_jump_addr, exp_q[0].addr);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Entry sequence from IDLE (or SERVICE when preempting). With with_reti
    // the request is raised together with a return pulse.
    task automatic do_irq(input int n, input int ack_dly, input bit wr_latch,
                          input bit drop_en, input bit with_reti);
        bus.i_irq        = 1'b1;
        bus.i_irq_addr   = 5'(n);
        bus.i_cpu_int_en = 1'b1;
        bus.i_jump_ack   = (ack_dly == 0);
        push_exp(n);
        if (with_reti) begin
            bus.i_reti = 1'b1;
            tick();
            bus.i_reti = 1'b0;
            chk("reti_first_in_isr", 32'(bus.o_in_isr), 0);
        end
        tick();
        chk("latch_no_req", 32'(bus.o_jump_req), 0);
        if (wr_latch) table_write(n, $urandom);
        if (drop_en) bus.i_cpu_int_en = 1'b0;
        tick();
        bus.i_vt_we = 1'b0;
        chk("latency_req", 32'(bus.o_jump_req), 1);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk("jump_hold", 32'(bus.o_jump_req), 1);
        end
        bus.i_jump_ack = 1'b1;
        tick();
        bus.i_jump_ack = 1'b0;
        chk("ack_pulse", 32'(bus.o_irq_ack), 1);
        chk("req_drop", 32'(bus.o_jump_req), 0);
        bus.i_irq        = 1'b0;
        bus.i_cpu_int_en = 1'b1;
        tick();
        chk("ack_one_cycle", 32'(bus.o_irq_ack), 0);
        chk("svc_in_isr", 32'(bus.o_in_isr), 1);
        chk("svc_cur_irq", 32'(bus.o_cur_irq), 32'(n));
    endtask

    task automatic do_reti();
        bus.i_reti = 1'b1;
        tick();
        bus.i_reti = 1'b0;
        chk("reti_in_isr", 32'(bus.o_in_isr), 0);
    endtask

    // Requests that must never be taken: enable low, or number 31.
    task automatic idle_noise(input int cycles, input bit force_dis);
        for (int i = 0; i < cycles; i++) begin
            bus.i_irq = 1'b1;
            if (force_dis || $urandom_range(0, 1) == 0) begin
                bus.i_cpu_int_en = 1'b0;
                bus.i_irq_addr   = 5'($urandom_range(0, 31));
            end else begin
                bus.i_cpu_int_en = 1'b1;
                bus.i_irq_addr   = 5'd31;
            end
            bus.i_reti = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) table_write($urandom_range(0, 31), $urandom);
            tick();
            bus.i_vt_we = 1'b0;
            bus.i_reti  = 1'b0;
            chk("idle_no_req", 32'(bus.o_jump_req), 0);
            chk("idle_no_isr", 32'(bus.o_in_isr), 0);
        end
        bus.i_irq        = 1'b0;
        bus.i_cpu_int_en = 1'b1;
    endtask

    task automatic service_noise(input int cycles, input int cur);
        for (int i = 0; i < cycles; i++) begin
            bus.i_irq = $urandom_range(0, 1);
`ifdef VIC_CPU_IF_NEST_EN
            bus.i_irq_addr = 5'($urandom_range(cur, 31));
`else
            bus.i_irq_addr = 5'($urandom_range(0, 31));
`endif
            tick();
            chk("svc_no_req", 32'(bus.o_jump_req), 0);
            chk("svc_hold_cur", 32'(bus.o_cur_irq), 32'(cur));
        end
        bus.i_irq = 1'b0;
    endtask

    initial begin
        int  n;
        bit  in_svc;
        total = 0;
        bad   = 0;
        model_reset();
        rst              = 1'b1;
        bus.i_irq        = 1'b0;
        bus.i_irq_addr   = '0;
        bus.i_cpu_int_en = 1'b1;
        bus.i_vt_we      = 1'b0;
        bus.i_vt_addr    = '0;
        bus.i_vt_data    = '0;
        bus.i_jump_ack   = 1'b0;
        bus.i_reti       = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_jump_req", 32'(bus.o_jump_req), 0);
        chk("rst_jump_addr", bus.o_jump_addr, 0);
        chk("rst_irq_ack", 32'(bus.o_irq_ack), 0);
        chk("rst_in_isr", 32'(bus.o_in_isr), 0);
        chk("rst_cur_irq", 32'(bus.o_cur_irq), 0);

        // Entry for source 5 with the core accepting immediately.
        do_irq(5, 0, 0, 0, 0);
        chk("vec5_addr", bus.o_jump_addr, 32'h0000_0114);
        do_reti();

        // Disabled interrupts for ten cycles, then enable.
        idle_noise(10, 1);
        do_irq(4, 1, 0, 0, 0);
        do_reti();

        // Reprogrammed entry with a slow core.
        table_write(3, 32'hDEAD_0000);
        tick();
        bus.i_vt_we = 1'b0;
        do_irq(3, 4, 0, 0, 0);
        chk("vec3_prog", bus.o_jump_addr, 32'hDEAD_0000);
        do_reti();

        in_svc = 1'b0;
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 30);
            if (in_svc && $urandom_range(0, 2) == 0) begin
                do_irq(n, $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 1), 1);
            end else begin
                if (in_svc) do_reti();
                idle_noise($urandom_range(0, 4), 0);
                do_irq(n, $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 1), 0);
            end
            in_svc = 1'b1;
            service_noise($urandom_range(0, 3), n);
        end
        do_reti();

        // Reset in the middle of a redirect.
        table_write(3, 32'hDEAD_0000);
        tick();
        bus.i_vt_we      = 1'b0;
        bus.i_irq        = 1'b1;
        bus.i_irq_addr   = 5'd3;
        bus.i_jump_ack   = 1'b0;
        push_exp(3);
        tick();
        tick();
        chk("pre_rst_req", 32'(bus.o_jump_req), 1);
        rst       = 1'b1;
        bus.i_irq = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        chk("mid_rst_req", 32'(bus.o_jump_req), 0);
        chk("mid_rst_addr", bus.o_jump_addr, 0);
        chk("mid_rst_isr", 32'(bus.o_in_isr), 0);
        tick();
        chk("post_rst_idle", 32'(bus.o_jump_req), 0);
        do_irq(3, 1, 0, 0, 0);
        chk("vec3_reloaded", bus.o_jump_addr, 32'h0000_010C);
        do_reti();

`ifdef VIC_CPU_IF_NEST_EN
        do_irq(7, 0, 0, 0, 0);
        do_irq(2, 1, 0, 0, 0);
        bus.i_reti = 1'b1;
        tick();
        bus.i_reti = 1'b0;
        chk("nest_pop_isr", 32'(bus.o_in_isr), 1);
        chk("nest_pop_cur", 32'(bus.o_cur_irq), 7);
        do_reti();
        do_irq(7, 0, 0, 0, 0);
        bus.i_irq      = 1'b1;
        bus.i_irq_addr = 5'd9;
        repeat (5) begin
            tick();
            chk("nest_low_ignored", 32'(bus.o_jump_req), 0);
            chk("nest_low_cur", 32'(bus.o_cur_irq), 7);
        end
        bus.i_irq = 1'b0;
        do_reti();
`endif

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/vic_cpu_if.md
VIC_CPU_IF -- requirements
Module: vic_cpu_if

Interface
REQ-001 SHALL have parameter VT_RESET_BASE, default 32'h0000_0100, giving vector-table reset contents: entry n = VT_RESET_BASE + 4*n.
REQ-002 SHALL have parameter NEST_DEPTH, default 4, giving preemption stack depth (used only with VIC_CPU_IF_NEST_EN).
REQ-003 SHALL have port i_clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_irq, input, 1, level request from interrupt controller.
REQ-006 SHALL have port i_irq_addr, input, 5, number of the pending source, valid while i_irq=1.
REQ-007 SHALL have port o_irq_ack, output, 1, one-cycle pulse: the current source is taken; the controller clears it and may present the next one.
REQ-008 SHALL have port i_cpu_int_en, input, 1, global CPU interrupt enable.
REQ-009 SHALL have ports i_vt_we (input, 1), i_vt_addr (input, 5) and i_vt_data (input, 32), forming the vector-table write port; address 31 SHALL be ignored.
REQ-010 SHALL have ports o_jump_req (output, 1) and o_jump_addr (output, 32), forming the redirect request to the core.
REQ-011 SHALL have port i_jump_ack, input, 1, core acceptance of the redirect.
REQ-012 SHALL have port i_reti, input, 1, one-cycle return-from-interrupt pulse.
REQ-013 SHALL have ports o_in_isr (output, 1) and o_cur_irq (output, 5), giving the currently serviced source.

Function
REQ-014 SHALL hold a 31 x 32-bit vector table; a write lands on the edge where i_vt_we=1.
REQ-015 SHALL implement states IDLE, LATCH, JUMP, ACK and SERVICE.
REQ-016 IDLE -> LATCH when i_irq=1, i_cpu_int_en=1 and i_irq_addr<31; in that case the block SHALL register i_irq_addr.
REQ-017 In LATCH the block SHALL register table[latched number] into o_jump_addr; a same-cycle table write to that entry SHALL NOT affect this read (old value is used).
REQ-018 JUMP SHALL assert o_jump_req with o_jump_addr held stable until a cycle with i_jump_ack=1, then go to ACK.
REQ-019 Latency from i_irq sampled in IDLE (cycle 0) to o_jump_req=1 SHALL be exactly 2 cycles.
REQ-020 ACK SHALL pulse o_irq_ack for one cycle, set o_in_isr=1 and o_cur_irq to the latched number, then go to SERVICE.
REQ-021 In SERVICE, i_reti SHALL return the block to IDLE with o_in_isr=0 (REQ-030 applies when nested).
REQ-022 i_reti outside SERVICE SHALL be ignored.
REQ-023 If i_reti and i_irq occur in the same cycle, the return SHALL be processed first and i_irq re-sampled no earlier than the next cycle.
REQ-024 If i_cpu_int_en falls during LATCH or JUMP, the sequence SHALL complete; the enable gates only new entry from IDLE and preemption.
REQ-025 Number 31 presented on i_irq_addr SHALL never be taken (treated as no request).

Reset
REQ-026 On i_rst=1 at a clock edge the block SHALL enter IDLE from any state, including mid-JUMP.
REQ-027 After reset: o_jump_req=0, o_jump_addr=0, o_irq_ack=0, o_in_isr=0, o_cur_irq=0, stack empty, table reloaded per REQ-001.

Configuration
REQ-028 Macro VIC_CPU_IF_NEST_EN SHALL select whether preemption is compiled in.
REQ-029 With VIC_CPU_IF_NEST_EN defined: in SERVICE, if i_irq=1, i_cpu_int_en=1, i_irq_addr<o_cur_irq and the stack is not full, the block SHALL push o_cur_irq and go to LATCH; lower number = higher priority.
REQ-030 With VIC_CPU_IF_NEST_EN defined: i_reti with a non-empty stack SHALL pop into o_cur_irq and stay in SERVICE; with an empty stack it SHALL go to IDLE.
REQ-031 With VIC_CPU_IF_NEST_EN defined: when the stack is full, preemption SHALL be blocked.
REQ-032 Without VIC_CPU_IF_NEST_EN: no stack SHALL exist, SERVICE SHALL ignore i_irq, and NEST_DEPTH SHALL be unused.

Verification
REQ-033 Reset, i_irq=1, i_irq_addr=5, i_jump_ack tied 1 -> o_jump_req high in cycle 2 with o_jump_addr=32'h0000_0114; o_irq_ack pulses in cycle 3; o_cur_irq=5.
REQ-034 Write table[3]=32'hDEAD_0000, then request 3 with i_jump_ack delayed 4 cycles -> o_jump_addr=32'hDEAD_0000 held stable, o_jump_req high for exactly 5 cycles.
REQ-035 i_cpu_int_en=0 with i_irq=1 for 10 cycles -> stays IDLE and o_irq_ack never pulses; raising i_cpu_int_en -> normal entry.
REQ-036 NEST_EN: servicing 7, request 2 -> o_cur_irq=2, first i_reti -> o_cur_irq=7, second i_reti -> IDLE; request 9 during 7 -> ignored.
REQ-037 i_rst asserted while o_jump_req=1 -> next cycle o_jump_req=0, IDLE, table entry 3 = 32'h0000_010C.
